// File: rtl/apb_ram_pkg.sv
// apb_ram_pkg: shared types and constants for the APB RAM completer.
//   apb_state_e   - completer FSM states
//   ram_wr_t      - latched RAM write payload (byte enables + data)
//   APB_DATA_BITS - supported APB data width
//   RD_BYTEENA    - byte enables driven to the RAM on reads
package apb_ram_pkg;

  localparam int unsigned APB_DATA_BITS = 32;
  localparam int unsigned APB_STRB_BITS = APB_DATA_BITS / 8;
  localparam int unsigned WAIT_CNT_BITS = 4;

  localparam logic [APB_STRB_BITS-1:0] RD_BYTEENA = 4'hf;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_STRB_BITS-1:0] byteena;
    logic [APB_DATA_BITS-1:0] data;
  } ram_wr_t;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: loadable down-counter with a zero flag.
//   clk, rst_n  - clock, async active-low reset
//   load_i      - load load_val_i (has priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one, saturating at zero
//   count_o     - current count (registered)
//   zero_c      - count is zero (decoded from the register)
module apb_wait_timer
  import apb_ram_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [WAIT_CNT_BITS-1:0] load_val_i,
  input  logic                     dec_i,
  output logic [WAIT_CNT_BITS-1:0] count_o,
  output logic                     zero_c
);

  logic [WAIT_CNT_BITS-1:0] cnt_q, cnt_d;

  // Next count: load wins, decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_c  = (cnt_q == '0);

endmodule

// File: rtl/apb_ram_slave.sv
// apb_ram_slave: APB3/APB4 completer backed by a 1-cycle-latency single-port RAM.
//   apb_clock, resetn      - clock, async active-low reset
//   apb_psel/penable/...   - APB completer port (pprot accepted, ignored)
//   apb_pready/pslverr     - one-cycle completion, error response
//   apb_prdata             - read data, non-zero only in the completion cycle
//   ram_addr/byteena/data  - RAM word address, byte enables, write data (held)
//   ram_wren, ram_rden     - single-cycle RAM strobes
//   ram_q                  - RAM read data, valid the cycle after ram_rden
// Build option: APB_RAM_SLAVE_SLVERR_EN enables out-of-window / misaligned
// error decode; without it the window aliases and pslverr stays 0.
module apb_ram_slave
  import apb_ram_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned DATA_BITS   = APB_DATA_BITS,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 apb_clock,
  input  logic                 resetn,
  input  logic                 apb_psel,
  input  logic                 apb_penable,
  input  logic                 apb_pwrite,
  input  logic [31:0]          apb_paddr,
  input  logic [DATA_BITS-1:0] apb_pwdata,
  input  logic [3:0]           apb_pstrb,
  input  logic [2:0]           apb_pprot,
  output logic                 apb_pready,
  output logic                 apb_pslverr,
  output logic [DATA_BITS-1:0] apb_prdata,
  output logic [ADDR_BITS-3:0] ram_addr,
  output logic [3:0]           ram_byteena,
  output logic [31:0]          ram_data,
  output logic                 ram_wren,
  output logic                 ram_rden,
  input  logic [31:0]          ram_q
);

  localparam int unsigned WORD_BITS = ADDR_BITS - 2;
  localparam logic [WAIT_CNT_BITS-1:0] WAIT_LOAD = WAIT_CNT_BITS'(WAIT_STATES);

  apb_state_e           state_q, state_d;
  logic                 write_q, write_d;
  logic                 err_q, err_d;
  logic [WORD_BITS-1:0] addr_q, addr_d;
  ram_wr_t              wr_q, wr_d;
  logic                 wren_q, wren_d;
  logic                 rden_q, rden_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATA_BITS-1:0] prdata_q, prdata_d;

  logic                     tmr_load_c;
  logic                     tmr_dec_c;
  logic [WAIT_CNT_BITS-1:0] tmr_count;
  logic                     tmr_zero_c;
  logic                     setup_err_c;

  // Bad-access decode, evaluated on the setup cycle
`ifdef APB_RAM_SLAVE_SLVERR_EN
  assign setup_err_c = (apb_paddr[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]) ||
                       (apb_paddr[1:0] != 2'b00);
`else
  assign setup_err_c = 1'b0;
`endif

  // Address bits outside the word index and pprot are intentionally ignored
  logic unused_ok;
  assign unused_ok = ^{apb_pprot, apb_paddr[31:ADDR_BITS], apb_paddr[1:0], BASE_ADDR};

  apb_wait_timer u_wait_timer (
    .clk        (apb_clock),
    .rst_n      (resetn),
    .load_i     (tmr_load_c),
    .load_val_i (WAIT_LOAD),
    .dec_i      (tmr_dec_c),
    .count_o    (tmr_count),
    .zero_c     (tmr_zero_c)
  );

  // Next state and registered outputs. RAM strobes are decided one cycle
  // ahead so they land in the last ACCESS cycle (T1+W).
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wren_d     = 1'b0;
    rden_d     = 1'b0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (apb_psel && !apb_penable) begin
          state_d      = ST_ACCESS;
          write_d      = apb_pwrite;
          err_d        = setup_err_c;
          addr_d       = apb_paddr[ADDR_BITS-1:2];
          wr_d.data    = APB_DATA_BITS'(apb_pwdata);
          wr_d.byteena = apb_pwrite ? apb_pstrb : RD_BYTEENA;
          tmr_load_c   = 1'b1;
          if ((WAIT_STATES == 0) && !setup_err_c) begin
            wren_d = apb_pwrite;
            rden_d = !apb_pwrite;
          end
        end
      end

      ST_ACCESS: begin
        if (!apb_psel) begin
          state_d = ST_IDLE;
        end else if (!tmr_zero_c) begin
          tmr_dec_c = 1'b1;
          if ((tmr_count == WAIT_CNT_BITS'(1)) && !err_q) begin
            wren_d = write_q;
            rden_d = !write_q;
          end
        end else if (err_q || write_q) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = err_q;
        end else begin
          state_d = ST_RDWAIT;
        end
      end

      ST_RDWAIT: begin
        if (!apb_psel) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
          prdata_d = DATA_BITS'(ram_q);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_q      <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;
  assign apb_prdata  = prdata_q;
  assign ram_addr    = addr_q;
  assign ram_byteena = wr_q.byteena;
  assign ram_data    = wr_q.data;
  assign ram_wren    = wren_q;
  assign ram_rden    = rden_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
// Bench for apb_ram_slave: three instances (WAIT_STATES 0, 2, 3) on a shared
// APB bus, each selected individually and backed by its own RAM model.
module tb_apb_ram_slave;

  localparam int unsigned NDUT = 3;
  localparam int unsigned AW   = 12;

  logic        apb_clock = 1'b0;
  logic        resetn;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_paddr, apb_pwdata;
  logic [3:0]  apb_pstrb;
  logic [2:0]  apb_pprot;
  int          tgt;

  logic [NDUT-1:0] psel_w, pready_w, pslverr_w, wren_w, rden_w;
  logic [31:0]     prdata_w [NDUT];
  logic [AW-3:0]   raddr_w  [NDUT];
  logic [3:0]      be_w     [NDUT];
  logic [31:0]     data_w   [NDUT];

  int compared;
  int mismatched;
  int wren_cnt [NDUT];
  int rden_cnt [NDUT];

  typedef struct {
    int          rdy;
    int          wr_at;
    int          rd_at;
    int          wr_n;
    int          rd_n;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  always #5 apb_clock = ~apb_clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    logic [31:0] mem [1 << (AW - 2)];
    logic [31:0] q;

    assign psel_w[g] = apb_psel && (tgt == g);

    apb_ram_slave #(
      .ADDR_BITS   (AW),
      .DATA_BITS   (32),
      .BASE_ADDR   (32'h0),
      .WAIT_STATES (W)
    ) u_dut (
      .apb_clock   (apb_clock),
      .resetn      (resetn),
      .apb_psel    (psel_w[g]),
      .apb_penable (apb_penable),
      .apb_pwrite  (apb_pwrite),
      .apb_paddr   (apb_paddr),
      .apb_pwdata  (apb_pwdata),
      .apb_pstrb   (apb_pstrb),
      .apb_pprot   (apb_pprot),
      .apb_pready  (pready_w[g]),
      .apb_pslverr (pslverr_w[g]),
      .apb_prdata  (prdata_w[g]),
      .ram_addr    (raddr_w[g]),
      .ram_byteena (be_w[g]),
      .ram_data    (data_w[g]),
      .ram_wren    (wren_w[g]),
      .ram_rden    (rden_w[g]),
      .ram_q       (q)
    );

    // Byte-enabled single-port RAM, one cycle read latency
    always @(posedge apb_clock) begin
      if (wren_w[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (be_w[g][b]) mem[raddr_w[g]][8*b +: 8] <= data_w[g][8*b +: 8];
        end
      end
      if (rden_w[g]) q <= mem[raddr_w[g]];
    end
  end

  always @(negedge apb_clock) begin
    for (int g = 0; g < NDUT; g++) begin
      if (wren_w[g]) wren_cnt[g] <= wren_cnt[g] + 1;
      if (rden_w[g]) rden_cnt[g] <= rden_cnt[g] + 1;
    end
  end

  // One APB transfer; T0 is the cycle after the call. Cycle numbers in o are
  // relative to T0. Returns in the completion cycle with psel still high.
  task automatic apb_xfer(input int g, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output obs_t o);
    o.rdy = -1; o.wr_at = -1; o.rd_at = -1; o.wr_n = 0; o.rd_n = 0;
    o.addr = '0; o.be = '0; o.rdata = '0; o.err = 1'b0;
    @(posedge apb_clock); #1;
    tgt = g; apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr;
    apb_paddr = addr; apb_pwdata = wdata; apb_pstrb = strb;
    for (int c = 1; c <= 40; c++) begin
      @(posedge apb_clock); #1;
      apb_penable = 1'b1;
      if (wren_w[g]) begin o.wr_n++; o.wr_at = c; o.addr = raddr_w[g]; o.be = be_w[g]; end
      if (rden_w[g]) begin o.rd_n++; o.rd_at = c; o.addr = raddr_w[g]; o.be = be_w[g]; end
      if (pready_w[g]) begin
        o.rdy = c; o.rdata = prdata_w[g]; o.err = pslverr_w[g];
        break;
      end
    end
  endtask

  task automatic bus_idle();
    @(posedge apb_clock); #1;
    apb_psel = 1'b0; apb_penable = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #3 resetn = 1'b0;
    repeat (3) @(posedge apb_clock);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      compared++;
      if ({pready_w[g], pslverr_w[g], wren_w[g], rden_w[g]} !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 0000", g,
                 {pready_w[g], pslverr_w[g], wren_w[g], rden_w[g]});
      end
      compared++;
      if ({prdata_w[g], raddr_w[g], be_w[g], data_w[g]} !== '0) begin
        mismatched++;
        $display("FAIL reset_data[%0d]: got prdata=%h addr=%h be=%h data=%h expected all 0",
                 g, prdata_w[g], raddr_w[g], be_w[g], data_w[g]);
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    obs_t o;
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, o);
    compared++;
    if (o.wr_at !== 1 || o.wr_n !== 1 || o.addr !== 10'd4 || o.be !== 4'hf) begin
      mismatched++;
      $display("FAIL wr_strobe: got at=%0d n=%0d addr=%0d be=%h expected at=1 n=1 addr=4 be=f",
               o.wr_at, o.wr_n, o.addr, o.be);
    end
    compared++;
    if (o.rdy !== 2 || o.err !== 1'b0) begin
      mismatched++;
      $display("FAIL wr_ready: got cycle=%0d err=%b expected cycle=2 err=0", o.rdy, o.err);
    end
    bus_idle();
    compared++;
    if (pready_w[0] !== 1'b0 || raddr_w[0] !== 10'd4) begin
      mismatched++;
      $display("FAIL wr_after: got pready=%b addr=%0d expected pready=0 addr=4",
               pready_w[0], raddr_w[0]);
    end
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, o);
    compared++;
    if (o.rd_at !== 1 || o.rd_n !== 1 || o.be !== 4'hf || o.wr_n !== 0) begin
      mismatched++;
      $display("FAIL rd_strobe: got at=%0d n=%0d be=%h wr_n=%0d expected at=1 n=1 be=f wr_n=0",
               o.rd_at, o.rd_n, o.be, o.wr_n);
    end
    compared++;
    if (o.rdy !== 3 || o.rdata !== 32'hDEADBEEF || o.err !== 1'b0) begin
      mismatched++;
      $display("FAIL rd_data: got cycle=%0d data=%h err=%b expected cycle=3 data=deadbeef err=0",
               o.rdy, o.rdata, o.err);
    end
    bus_idle();
    compared++;
    if (prdata_w[0] !== 32'h0) begin
      mismatched++;
      $display("FAIL rd_prdata_idle: got %h expected 00000000", prdata_w[0]);
    end
  endtask

  task automatic test_byte_strobe();
    obs_t o;
    apb_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hf, o);
    apb_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, o);
    compared++;
    if (o.be !== 4'h5 || o.wr_n !== 1) begin
      mismatched++;
      $display("FAIL strb_be: got be=%h n=%0d expected be=5 n=1", o.be, o.wr_n);
    end
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, o);
    compared++;
    if (o.rdata !== 32'h11BB33DD) begin
      mismatched++;
      $display("FAIL strb_merge: got %h expected 11bb33dd", o.rdata);
    end
    apb_xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, o);
    compared++;
    if (o.wr_n !== 1 || o.be !== 4'h0 || o.rdy !== 2) begin
      mismatched++;
      $display("FAIL strb_zero: got n=%0d be=%h cycle=%0d expected n=1 be=0 cycle=2",
               o.wr_n, o.be, o.rdy);
    end
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, o);
    compared++;
    if (o.rdata !== 32'h11BB33DD) begin
      mismatched++;
      $display("FAIL strb_zero_keep: got %h expected 11bb33dd", o.rdata);
    end
    bus_idle();
  endtask

  task automatic test_wait_states();
    obs_t o;
    int   r0;
    apb_xfer(2, 1'b1, 32'h10, 32'hCAFEF00D, 4'hf, o);
    compared++;
    if (o.wr_at !== 4 || o.rdy !== 5) begin
      mismatched++;
      $display("FAIL ws_write: got wren=%0d ready=%0d expected wren=4 ready=5", o.wr_at, o.rdy);
    end
    bus_idle();
    r0 = rden_cnt[2];
    apb_xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, o);
    compared++;
    if (o.rd_at !== 4 || o.rd_n !== 1 || o.rdy !== 6 || o.rdata !== 32'hCAFEF00D) begin
      mismatched++;
      $display("FAIL ws_read: got rden=%0d n=%0d ready=%0d data=%h expected rden=4 n=1 ready=6 data=cafef00d",
               o.rd_at, o.rd_n, o.rdy, o.rdata);
    end
    bus_idle();
    repeat (2) @(posedge apb_clock);
    #1;
    compared++;
    if (rden_cnt[2] - r0 !== 1) begin
      mismatched++;
      $display("FAIL ws_rden_count: got %0d expected 1", rden_cnt[2] - r0);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    int   w0;
    logic saw_ready;
    apb_xfer(2, 1'b1, 32'h14, 32'h0BADF00D, 4'hf, o);
    bus_idle();
    w0 = wren_cnt[2];
    saw_ready = 1'b0;
    @(posedge apb_clock); #1;
    tgt = 2; apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1;
    apb_paddr = 32'h14; apb_pwdata = 32'h12345678; apb_pstrb = 4'hf;
    @(posedge apb_clock); #1;
    apb_penable = 1'b1;
    @(posedge apb_clock); #1;
    apb_psel = 1'b0; apb_penable = 1'b0;
    repeat (8) begin
      @(posedge apb_clock); #1;
      if (pready_w[2]) saw_ready = 1'b1;
    end
    compared++;
    if (wren_cnt[2] - w0 !== 0 || saw_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL abort: got wren=%0d pready_seen=%b expected wren=0 pready_seen=0",
               wren_cnt[2] - w0, saw_ready);
    end
    apb_xfer(2, 1'b0, 32'h14, 32'h0, 4'h0, o);
    compared++;
    if (o.rdy !== 6 || o.rdata !== 32'h0BADF00D) begin
      mismatched++;
      $display("FAIL abort_after: got ready=%0d data=%h expected ready=6 data=0badf00d",
               o.rdy, o.rdata);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int   w0;
    w0 = wren_cnt[0];
    for (int i = 0; i < 8; i++) begin
      apb_xfer(0, 1'b1, 32'(4 * i), 32'hB0000000 + 32'(i), 4'hf, o);
      compared++;
      if (o.rdy !== 2 || o.wr_n !== 1 || o.addr !== 10'(i)) begin
        mismatched++;
        $display("FAIL b2b[%0d]: got ready=%0d n=%0d addr=%0d expected ready=2 n=1 addr=%0d",
                 i, o.rdy, o.wr_n, o.addr, i);
      end
    end
    bus_idle();
    repeat (2) @(posedge apb_clock);
    #1;
    compared++;
    if (wren_cnt[0] - w0 !== 8) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d expected 8", wren_cnt[0] - w0);
    end
    apb_xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, o);
    compared++;
    if (o.rdata !== 32'hB0000007) begin
      mismatched++;
      $display("FAIL b2b_readback: got %h expected b0000007", o.rdata);
    end
    bus_idle();
  endtask

  task automatic test_error();
    obs_t o;
    int   s0;
    s0 = wren_cnt[0] + rden_cnt[0];
    apb_xfer(0, 1'b0, 32'h1002, 32'h0, 4'h0, o);
`ifdef APB_RAM_SLAVE_SLVERR_EN
    compared++;
    if (o.rdy !== 2 || o.err !== 1'b1 || o.rdata !== 32'h0 || (o.rd_n + o.wr_n) !== 0) begin
      mismatched++;
      $display("FAIL err_read: got ready=%0d err=%b data=%h strobes=%0d expected ready=2 err=1 data=0 strobes=0",
               o.rdy, o.err, o.rdata, o.rd_n + o.wr_n);
    end
    apb_xfer(0, 1'b1, 32'h2000, 32'h55555555, 4'hf, o);
    compared++;
    if (o.rdy !== 2 || o.err !== 1'b1 || o.wr_n !== 0) begin
      mismatched++;
      $display("FAIL err_write: got ready=%0d err=%b wr_n=%0d expected ready=2 err=1 wr_n=0",
               o.rdy, o.err, o.wr_n);
    end
    bus_idle();
    repeat (2) @(posedge apb_clock);
    #1;
    compared++;
    if (wren_cnt[0] + rden_cnt[0] - s0 !== 0) begin
      mismatched++;
      $display("FAIL err_strobes: got %0d expected 0", wren_cnt[0] + rden_cnt[0] - s0);
    end
`else
    compared++;
    if (o.rdy !== 3 || o.err !== 1'b0 || o.addr !== 10'd0 || o.rdata !== 32'hB0000000) begin
      mismatched++;
      $display("FAIL alias_read: got ready=%0d err=%b addr=%0d data=%h expected ready=3 err=0 addr=0 data=b0000000",
               o.rdy, o.err, o.addr, o.rdata);
    end
    bus_idle();
    repeat (2) @(posedge apb_clock);
    #1;
    compared++;
    if (wren_cnt[0] + rden_cnt[0] - s0 !== 1) begin
      mismatched++;
      $display("FAIL alias_strobes: got %0d expected 1", wren_cnt[0] + rden_cnt[0] - s0);
    end
`endif
    apb_xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, o);
    compared++;
    if (o.err !== 1'b0 || o.rdata !== 32'hB0000007) begin
      mismatched++;
      $display("FAIL err_recover: got err=%b data=%h expected err=0 data=b0000007", o.err, o.rdata);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    int   w0;
    w0 = wren_cnt[1];
    @(posedge apb_clock); #1;
    tgt = 1; apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1;
    apb_paddr = 32'h8; apb_pwdata = 32'h00000055; apb_pstrb = 4'hf;
    @(posedge apb_clock); #1;
    apb_penable = 1'b1;
    @(posedge apb_clock); #1;
    resetn = 1'b0;
    #1;
    compared++;
    if ({pready_w[1], pslverr_w[1], wren_w[1], rden_w[1], prdata_w[1], raddr_w[1], be_w[1], data_w[1]} !== '0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got addr=%0d be=%h data=%h wren=%b expected all 0",
               raddr_w[1], be_w[1], data_w[1], wren_w[1]);
    end
    apb_psel = 1'b0; apb_penable = 1'b0;
    repeat (3) @(posedge apb_clock);
    #1;
    resetn = 1'b1;
    repeat (4) @(posedge apb_clock);
    #1;
    compared++;
    if (wren_cnt[1] - w0 !== 0) begin
      mismatched++;
      $display("FAIL rst_mid_wren: got %0d expected 0", wren_cnt[1] - w0);
    end
    apb_xfer(1, 1'b1, 32'h8, 32'h00000077, 4'hf, o);
    compared++;
    if (o.wr_at !== 3 || o.rdy !== 4 || o.addr !== 10'd2) begin
      mismatched++;
      $display("FAIL rst_mid_next_wr: got wren=%0d ready=%0d addr=%0d expected wren=3 ready=4 addr=2",
               o.wr_at, o.rdy, o.addr);
    end
    apb_xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, o);
    compared++;
    if (o.rd_at !== 3 || o.rdy !== 5 || o.rdata !== 32'h00000077) begin
      mismatched++;
      $display("FAIL rst_mid_next_rd: got rden=%0d ready=%0d data=%h expected rden=3 ready=5 data=00000077",
               o.rd_at, o.rdy, o.rdata);
    end
    bus_idle();
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    tgt         = 0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
    apb_paddr   = '0;
    apb_pwdata  = '0;
    apb_pstrb   = '0;
    apb_pprot   = 3'b000;
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_wait_states();
    test_abort();
    test_back_to_back();
    test_error();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
